btn_debounce: RTL and testbench

Conditions a raw, asynchronous push-button pin into clean, single-clock-domain control signals. It sits between the button's input buffer and the LED pattern and fade logic on the board clock. It provides three things:
- a debounced level, which drives the "hold" input of the fade counter;
- one-cycle press and release strobes;
- a long-press strobe and level, for mode switching.

---
 rtl/btn_debounce.sv | 168 ++++++++++++++++
 tb/tb_btn_debounce.sv | 122 ++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronizer, debounce FSM, press/release strobes
// and long-press detection, all registered on the single board clock.
module btn_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned LONG_CYCLES     = 12000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press,
  output logic release_o,
  output logic long_press,
  output logic held_long
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LW = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LCNT_LAST = LW'(LONG_CYCLES - 1);
  localparam logic          PIN_IDLE  = ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_q;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;

  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic long_q, long_d;
  logic held_q, held_d;

  logic accept_press;
  logic accept_release;
  logic long_hit;

  // Synchronizer chain plus one registered, polarity-corrected stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{PIN_IDLE}};
      s_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
      s_q    <= sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lcnt_q  <= lcnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    lcnt_d         = lcnt_q;
    accept_press   = 1'b0;
    accept_release = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = PRESSED;
          cnt_d        = '0;
          lcnt_d       = '0;
          accept_press = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        lcnt_d = (lcnt_q == LCNT_LAST) ? lcnt_q : lcnt_q + LW'(1);
        if (!s_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // The long counter keeps running across release bounces.
        lcnt_d = (lcnt_q == LCNT_LAST) ? lcnt_q : lcnt_q + LW'(1);
        if (s_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d        = IDLE;
          cnt_d          = '0;
          accept_release = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // held_q doubles as the fired flag; a concurrent release suppresses the event.
  always_comb begin
    long_hit  = ((state_q == PRESSED) || (state_q == RELEASE_WAIT)) &&
                !held_q && (lcnt_d == LCNT_LAST) && !accept_release;
    press_d   = accept_press;
    release_d = accept_release;
    long_d    = long_hit;
    level_d   = level_q;
    held_d    = held_q;
    if (accept_press)   level_d = 1'b1;
    if (accept_release) level_d = 1'b0;
    if (long_hit)       held_d  = 1'b1;
    if (accept_release) held_d  = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      held_q    <= held_d;
    end
  end

  assign btn_level  = level_q;
  assign press      = press_q;
  assign release_o  = release_q;
  assign long_press = long_q;
  assign held_long  = held_q;

  a_strobes_exclusive: assert property (@(posedge clk) disable iff (rst)
    $onehot0({press_q, release_q, long_q}));
  a_held_implies_level: assert property (@(posedge clk) disable iff (rst)
    held_q |-> level_q);

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=8,
// LONG_CYCLES=32, ACTIVE_LOW=1 (L = 11); edge k counts from the first driven edge.
module tb_btn_debounce;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic btn_level, press, release_o, long_press, held_long;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  btn_debounce #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(8),
    .LONG_CYCLES    (32),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .press     (press),
    .release_o (release_o),
    .long_press(long_press),
    .held_long (held_long)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got {lvl,prs,rel,lp,hl}=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int k, input bit lvl, input bit p,
                            input bit r, input bit lp, input bit hl);
    check($sformatf("%s@%0d", tag, k),
          {btn_level, press, release_o, long_press, held_long},
          {lvl, p, r, lp, hl});
  endtask

  task automatic idle(input string tag, input int n);
    btn_in = 1'b1;
    for (int k = 0; k < n; k++) begin
      tick();
      expect_out(tag, k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Hold pressed until edge 60 with an optional release glitch; press at 11,
  // long_press at 42, release at 71 regardless of a short glitch.
  task automatic press_hold(input string tag, input int gs, input int gl);
    for (int k = 0; k < 80; k++) begin
      btn_in = (k >= 60) || (k >= gs && k < gs + gl);
      tick();
      expect_out(tag, k, (k >= 11 && k < 71), (k == 11), (k == 71), (k == 42),
                 (k >= 42 && k < 71));
    end
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 1'b1;

    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out("reset", k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    idle("post_reset", 20);

    // Clean press at edge 0, release at edge 20.
    for (int k = 0; k < 40; k++) begin
      btn_in = (k >= 20);
      tick();
      expect_out("clean", k, (k >= 11 && k < 31), (k == 11), (k == 31), 1'b0, 1'b0);
    end
    idle("gap1", 4);

    // 7 low, 1 high, 7 low, high until 30, then held low from 30 to 50.
    for (int k = 0; k < 66; k++) begin
      btn_in = !((k < 7) || (k >= 8 && k < 15) || (k >= 30 && k < 50));
      tick();
      expect_out("bounce", k, (k >= 41 && k < 61), (k == 41), (k == 61), 1'b0, 1'b0);
    end
    idle("gap2", 4);

    press_hold("long", 0, 0);
    idle("gap3", 4);

    press_hold("glitch", 20, 5);
    idle("gap4", 4);

    // Reset while pressed, button kept low throughout.
    btn_in = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      expect_out("pre_rst", k, (k >= 11), (k == 11), 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    tick();
    expect_out("mid_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      expect_out("redetect", k, (k >= 11), (k == 11), 1'b0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
